// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encodings,
// flag bit positions and the stage-count helper.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit positions of the flags inside the internal flag vector.
  localparam int FLAG_Z    = 0;
  localparam int FLAG_OV   = 1;
  localparam int FLAG_CO   = 2;
  localparam int NUM_FLAGS = 3;

  // Number of CHUNK-bit slices needed to cover WIDTH bits.
  function automatic int stages(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One registered adder slice: sums a W-bit chunk of A and B' plus a carry-in
// and registers sum, carry-out and the beat's valid bit when enabled.
module addsub_stage #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic         valid_o,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0]   full_d;
  logic         valid_q;
  logic [W-1:0] sum_q;
  logic         cout_q;

  // Chunk sum with one extra bit to capture the carry out.
  always_comb begin
    full_d = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  end

  // Slice register; holds its contents whenever the pipeline is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      sum_q   <= full_d[W-1:0];
      cout_q  <= full_d[W];
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// CHUNK-bit slices, one register stage each; upper operand chunks are skewed
// so each slice sees its carry one cycle after the slice below produced it,
// and finished lower result chunks ride along with the wave to align.
// Optional feature macro: ADDSUB_SAT_EN (signed saturation on overflow).
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ov,
  output logic             Z
);

  localparam int STAGES = stages(WIDTH, CHUNK);

  // Handshake: a beat transfers on a rising edge where valid && ready.
  // The pipeline advances (adv) whenever the output slot is empty or being
  // consumed; in_ready equals adv, so out_valid && !out_ready freezes every
  // register including the result, and bubbles travel like ordinary beats.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  assign b_eff = (Ctrl == OP_SUB) ? ~B : B;
  assign cin0  = (Ctrl == OP_SUB);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] cout;
  logic [WIDTH-1:0]  part [STAGES];
  logic [1:0]        top_ab;
  logic              a_msb_q;
  logic              b_msb_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    localparam int CW = ((WIDTH - LO) < CHUNK) ? (WIDTH - LO) : CHUNK;

    logic [CW-1:0] a_k;
    logic [CW-1:0] b_k;
    logic [CW-1:0] sum_k;
    logic          cin_k;
    logic          vin_k;

    if (k == 0) begin : g_first
      assign a_k     = A[CW-1:0];
      assign b_k     = b_eff[CW-1:0];
      assign cin_k   = cin0;
      assign vin_k   = in_valid;
      assign part[0] = WIDTH'(sum_k);
    end else begin : g_skew
      logic [CW-1:0] a_dly_q [k];
      logic [CW-1:0] b_dly_q [k];
      logic [LO-1:0] lo_q;

      // Operand skew line (k cycles) and lower-result alignment register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            a_dly_q[j] <= '0;
            b_dly_q[j] <= '0;
          end
          lo_q <= '0;
        end else if (adv) begin
          a_dly_q[0] <= A[LO +: CW];
          b_dly_q[0] <= b_eff[LO +: CW];
          for (int j = 1; j < k; j++) begin
            a_dly_q[j] <= a_dly_q[j-1];
            b_dly_q[j] <= b_dly_q[j-1];
          end
          lo_q <= part[k-1][LO-1:0];
        end
      end

      assign a_k     = a_dly_q[k-1];
      assign b_k     = b_dly_q[k-1];
      assign cin_k   = cout[k-1];
      assign vin_k   = vld[k-1];
      assign part[k] = WIDTH'({sum_k, lo_q});
    end

    if (k == STAGES - 1) begin : g_msb
      assign top_ab = {a_k[CW-1], b_k[CW-1]};
    end

    addsub_stage #(.W(CW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (adv),
      .valid_i (vin_k),
      .a_i     (a_k),
      .b_i     (b_k),
      .cin_i   (cin_k),
      .valid_o (vld[k]),
      .sum_o   (sum_k),
      .cout_o  (cout[k])
    );
  end

  // Operand sign bits of the top slice, captured alongside its sum for Ov.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (adv) begin
      a_msb_q <= top_ab[1];
      b_msb_q <= top_ab[0];
    end
  end

  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_fin;
  logic             ov_raw;

  assign out_valid = vld[STAGES-1];
  assign s_raw     = part[STAGES-1];
  // Same-sign operands producing a different-sign result: carry into the MSB
  // differs from carry out of it.
  assign ov_raw    = (a_msb_q == b_msb_q) && (s_raw[WIDTH-1] != a_msb_q);

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Clamp on overflow; a wrapped negative result means the true value was positive.
  always_comb begin
    s_fin = s_raw;
    if (ov_raw) s_fin = s_raw[WIDTH-1] ? SMAX : SMIN;
  end
`else
  assign s_fin = s_raw;
`endif

  logic [NUM_FLAGS-1:0] flags;

  // Flags are only asserted alongside a valid result; Z follows the final S.
  always_comb begin
    flags          = '0;
    flags[FLAG_CO] = out_valid & cout[STAGES-1];
    flags[FLAG_OV] = out_valid & ov_raw;
    flags[FLAG_Z]  = out_valid & ~|s_fin;
  end

  assign S  = s_fin;
  assign Co = flags[FLAG_CO];
  assign Ov = flags[FLAG_OV];
  assign Z  = flags[FLAG_Z];

endmodule
